// File: rtl/sa_tile_controller.sv
// Tile sequencer for a ROWS x COLS weight-stationary systolic array:
// weight load, skewed input stream, drain, with stall and start/done handshake.
module sa_tile_controller #(
  parameter int unsigned ROWS  = 4,
  parameter int unsigned COLS  = 4,
  parameter int unsigned K_MAX = 16,
  parameter int unsigned CW    = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [$clog2(K_MAX+1)-1:0]   k_len_i,
  input  logic                         accumulate_i,
  input  logic                         ready_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic [2*ROWS-1:0]            pe_mode_o,
  output logic [ROWS-1:0]              add_zero_o,
  output logic [ROWS-1:0]              in_valid_o,
  output logic [COLS-1:0]              acc_valid_o,
  output logic                         acc_clear_o
);

  localparam int unsigned KW    = $clog2(K_MAX + 1);
  localparam int unsigned DRAIN = ROWS + COLS - 1;

  localparam logic [1:0] M_HOLD = 2'd0;
  localparam logic [1:0] M_PASS = 2'd1;
  localparam logic [1:0] M_LOAD = 2'd2;
  localparam logic [1:0] M_PROC = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PROC, S_DONE} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   p, p_n, p_last;
  logic [KW-1:0]   k, k_n;
  logic            acc, acc_n;
  logic            stall_n, err_n;

  logic [2*ROWS-1:0] pe_mode_n;
  logic [ROWS-1:0]   add_zero_n, in_valid_n;
  logic [COLS-1:0]   acc_valid_n;
  logic              acc_clear_n, busy_n, done_n;

  // Next state, phase counter and latched tile parameters.
  always_comb begin
    state_n = state;
    p_n     = p;
    k_n     = k;
    acc_n   = acc;
    stall_n = 1'b0;
    err_n   = 1'b0;
    p_last  = CW'(k) + CW'(DRAIN) - CW'(1);
    case (state)
      S_IDLE: begin
        if (start_i) begin
          if (k_len_i == '0) begin
            err_n = 1'b1;
          end else begin
            state_n = S_LOAD;
            p_n     = '0;
            k_n     = (k_len_i > KW'(K_MAX)) ? KW'(K_MAX) : k_len_i;
            acc_n   = accumulate_i;
          end
        end
      end
      S_LOAD: begin
        if (!ready_i) begin
          stall_n = 1'b1;
        end else if (p == CW'(ROWS - 1)) begin
          state_n = S_PROC;
          p_n     = '0;
        end else begin
          p_n = p + CW'(1);
        end
      end
      S_PROC: begin
        if (!ready_i) begin
          stall_n = 1'b1;
        end else if (p == p_last) begin
          state_n = S_DONE;
        end else begin
          p_n = p + CW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Output decode of the upcoming cycle's state and phase, registered below.
  always_comb begin
    pe_mode_n   = '0;
    add_zero_n  = '0;
    in_valid_n  = '0;
    acc_valid_n = '0;
    acc_clear_n = 1'b0;
    busy_n      = (state_n != S_IDLE);
    done_n      = (state_n == S_DONE);
    case (state_n)
      S_LOAD: begin
        if (!stall_n) begin
          for (int r = 0; r < int'(ROWS); r++)
            pe_mode_n[2*r +: 2] = (p_n == CW'(ROWS - 1)) ? M_LOAD : M_PASS;
        end
      end
      S_PROC: begin
        add_zero_n = ROWS'(1);
        if (!stall_n) begin
          for (int r = 0; r < int'(ROWS); r++) begin
            pe_mode_n[2*r +: 2] = M_PROC;
            in_valid_n[r] = (p_n >= CW'(r)) && (p_n < CW'(r) + CW'(k_n));
          end
          for (int c = 0; c < int'(COLS); c++)
            acc_valid_n[c] = (p_n >= CW'(c + ROWS)) && (p_n < CW'(c + ROWS) + CW'(k_n));
          acc_clear_n = (p_n == '0) && !acc_n;
        end
      end
      default: pe_mode_n = {ROWS{M_HOLD}};
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      p           <= '0;
      k           <= '0;
      acc         <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      pe_mode_o   <= '0;
      add_zero_o  <= '0;
      in_valid_o  <= '0;
      acc_valid_o <= '0;
      acc_clear_o <= 1'b0;
    end else begin
      state       <= state_n;
      p           <= p_n;
      k           <= k_n;
      acc         <= acc_n;
      busy_o      <= busy_n;
      done_o      <= done_n;
      err_o       <= err_n;
      pe_mode_o   <= pe_mode_n;
      add_zero_o  <= add_zero_n;
      in_valid_o  <= in_valid_n;
      acc_valid_o <= acc_valid_n;
      acc_clear_o <= acc_clear_n;
    end
  end

endmodule
